spi_xip_arbiter: RTL and testbench
==================================

Name: spi_xip_arbiter

Overview:
Wishbone master that owns the SPI master (spi_top) register bus and shares it between two requesters: an XIP flash-read port and a direct register-access port. Each XIP read is expanded into the fixed SPI register sequence: command, divider, slave select, go, poll, read RX0, deselect. Each register access is a single pass-through Wishbone transaction. Arbitration is round-robin, and a grant holds until its whole sequence completes.

Parameters:
DIVIDER, 32'h1, value written to the DIVIDER register (0x14) on every XIP read
SS_MASK, 8'h01, value written to the SS register (0x18) to select the flash
POLL_MAX, 16'd4096, maximum CTRL polls before an XIP read aborts with error

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
xip_req  in  1  XIP read request; held until xip_ack
xip_addr  in  24  flash byte address
xip_ack  out  1  one-cycle completion pulse
xip_rdata  out  32  read data, valid while xip_ack=1
xip_err  out  1  timeout flag, valid while xip_ack=1
reg_req  in  1  register access request; held until reg_ack
reg_we  in  1  1 = write
reg_adr  in  5  SPI register byte address
reg_wdata  in  32  write data
reg_sel  in  4  byte enables
reg_ack  out  1  one-cycle completion pulse
reg_rdata  out  32  read data, valid while reg_ack=1
wb_adr_o  out  5  Wishbone address to spi_top
wb_dat_o  out  32  Wishbone write data
wb_sel_o  out  4  Wishbone byte enables
wb_we_o  out  1  Wishbone write enable
wb_stb_o  out  1  Wishbone strobe
wb_cyc_o  out  1  Wishbone cycle
wb_dat_i  in  32  Wishbone read data from spi_top
wb_ack_i  in  1  Wishbone acknowledge from spi_top
busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): FSM enters IDLE. All outputs are 0. Poll counter is 0. Round-robin pointer is set to XIP.
- Wishbone bus cycle: cyc and stb assert together and hold, with adr/dat/sel/we stable, until the cycle where wb_ack_i=1. The outputs drop on the next edge. There is at least one idle cycle between consecutive bus cycles. wb_ack_i is ignored when stb=0.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the port that is not the pointer; the pointer then records the winner.
  - The decision registers in one cycle. Requests arriving mid-sequence wait.
- Register grant:
  - One bus cycle in state REG with reg_* copied.
  - On ack: reg_ack pulses for 1 cycle and reg_rdata = wb_dat_i captured on the ack edge. Return to IDLE.
  - Latency from reg_req to reg_ack is 2 cycles plus the slave wait.
- XIP grant: xip_addr is latched at grant. States in order, each one bus cycle (all writes use sel=4'hF):
  - CMD: adr 0x04, dat {8'h03, addr}.
  - DIV: adr 0x14, dat DIVIDER.
  - SS: adr 0x18, dat {24'b0, SS_MASK}.
  - GO: adr 0x10, dat 32'h0000_0140 (GO_BSY=bit8, CHAR_LEN=64).
  - POLL: read adr 0x10.
    - On ack with bit8=0: go to RX.
    - On ack with bit8=1: increment the counter. If the counter reaches POLL_MAX, set the error flag and go to DESEL. Otherwise issue the next poll after one idle cycle.
  - RX: read adr 0x00. Capture data_byteswapped = {d[7:0], d[15:8], d[23:16], d[31:24]}.
  - DESEL: write adr 0x18, dat 0.
  - RESP: pulse xip_ack for 1 cycle. xip_rdata is the captured word, or 0 on error; xip_err is the error flag. Clear the counter and flag, then return to IDLE.
- Deselect always runs, including after a timeout. The flash must never be left selected.
- Requester dropping its req mid-sequence: the sequence still completes, and the ack pulse is issued regardless.
- Reset asserted mid-sequence: the bus cycle is abandoned immediately (cyc=stb=0). No ack is issued.
- Simultaneous events: reg_req and xip_req rising on the same cycle with pointer=XIP → the register access goes first.

Test Plan:
- Reset hold, then release, with no requests → all outputs 0, busy=0, bus idle.
- XIP read at addr 0x001234, slave acks after 1 wait cycle, POLL returns bit8=1 twice then 0, RX0=0x11223344 → bus writes in order 0x04←0x03001234, 0x14←1, 0x18←1, 0x10←0x140; 3 polls; then read 0x00, write 0x18←0; xip_rdata=0x44332211, xip_err=0.
- Register write reg_adr=0x14, reg_wdata=0x5 → exactly one bus cycle carrying it; reg_ack 2 cycles after req with zero slave wait.
- reg_req and xip_req asserted together from reset, both held → register access completes first, then the full XIP sequence. Re-assert both after that → XIP now wins.
- POLL_MAX=4 and CTRL bit8 stuck at 1 → 4 polls, then deselect write, then xip_ack with xip_err=1 and xip_rdata=0.
- Reset pulse during the GO bus cycle → cyc/stb drop asynchronously, no ack is issued; a new XIP request afterwards restarts at CMD.

Source files
------------

// File: rtl/spi_xip_arbiter.sv
// Wishbone master for spi_top, shared round-robin between an XIP flash-read port and a register port.
// XIP reads expand into CMD/DIV/SS/GO/POLL/RX/DESEL bus cycles; a register access is one pass-through cycle.
module spi_xip_arbiter #(
   parameter logic [31:0] DIVIDER  = 32'h1,
   parameter logic [7:0]  SS_MASK  = 8'h01,
   parameter logic [15:0] POLL_MAX = 16'd4096
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        xip_req,
   input  logic [23:0] xip_addr,
   output logic        xip_ack,
   output logic [31:0] xip_rdata,
   output logic        xip_err,
   input  logic        reg_req,
   input  logic        reg_we,
   input  logic [4:0]  reg_adr,
   input  logic [31:0] reg_wdata,
   input  logic [3:0]  reg_sel,
   output logic        reg_ack,
   output logic [31:0] reg_rdata,
   output logic [4:0]  wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_stb_o,
   output logic        wb_cyc_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   output logic        busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_REG, S_CMD, S_DIV, S_SS, S_GO, S_POLL, S_RX, S_DESEL, S_RESP
   } state_t;

   state_t      state, state_nxt;
   logic        ptr_xip, ptr_nxt;
   logic [15:0] poll_cnt, cnt_nxt;
   logic        err_q, err_nxt;
   logic [31:0] rx_q, rx_nxt;
   logic        cyc_nxt, we_nxt, xack_nxt, xerr_nxt, rack_nxt;
   logic [4:0]  adr_nxt;
   logic [31:0] dat_nxt, xdat_nxt, rdat_nxt;
   logic [3:0]  sel_nxt;
   logic        grant_reg;

   assign wb_stb_o  = wb_cyc_o;
   assign busy      = (state != S_IDLE);
   // Both pending: the port that is not the pointer wins
   assign grant_reg = reg_req && (!xip_req || ptr_xip);

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr_xip;
      cnt_nxt   = poll_cnt;
      err_nxt   = err_q;
      rx_nxt    = rx_q;
      cyc_nxt   = wb_cyc_o;
      adr_nxt   = wb_adr_o;
      dat_nxt   = wb_dat_o;
      sel_nxt   = wb_sel_o;
      we_nxt    = wb_we_o;
      xack_nxt  = 1'b0;
      xdat_nxt  = xip_rdata;
      xerr_nxt  = xip_err;
      rack_nxt  = 1'b0;
      rdat_nxt  = reg_rdata;
      case (state)
         S_IDLE: begin
            if (grant_reg) begin
               state_nxt = S_REG;
               cyc_nxt   = 1'b1;
               adr_nxt   = reg_adr;
               dat_nxt   = reg_wdata;
               sel_nxt   = reg_sel;
               we_nxt    = reg_we;
               if (xip_req) ptr_nxt = 1'b0;
            end else if (xip_req) begin
               state_nxt = S_CMD;
               cyc_nxt   = 1'b1;
               adr_nxt   = 5'h04;
               dat_nxt   = {8'h03, xip_addr};
               sel_nxt   = 4'hF;
               we_nxt    = 1'b1;
               if (reg_req) ptr_nxt = 1'b1;
            end
         end
         S_REG: begin
            if (wb_cyc_o && wb_ack_i) begin
               cyc_nxt   = 1'b0;
               rack_nxt  = 1'b1;
               rdat_nxt  = wb_dat_i;
               state_nxt = S_IDLE;
            end
         end
         S_RESP: begin
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
            state_nxt = S_IDLE;
         end
         default: begin
            // Bus dropped on the previous ack: this cycle is the idle gap, start the next access
            if (!wb_cyc_o) begin
               cyc_nxt = 1'b1;
               sel_nxt = 4'hF;
               case (state)
                  S_DIV:   begin adr_nxt = 5'h14; dat_nxt = DIVIDER;            we_nxt = 1'b1; end
                  S_SS:    begin adr_nxt = 5'h18; dat_nxt = {24'b0, SS_MASK};   we_nxt = 1'b1; end
                  S_GO:    begin adr_nxt = 5'h10; dat_nxt = 32'h0000_0140;      we_nxt = 1'b1; end
                  S_POLL:  begin adr_nxt = 5'h10; dat_nxt = '0;                 we_nxt = 1'b0; end
                  S_RX:    begin adr_nxt = 5'h00; dat_nxt = '0;                 we_nxt = 1'b0; end
                  S_DESEL: begin adr_nxt = 5'h18; dat_nxt = '0;                 we_nxt = 1'b1; end
                  default: begin end
               endcase
            end else if (wb_ack_i) begin
               cyc_nxt = 1'b0;
               case (state)
                  S_CMD: state_nxt = S_DIV;
                  S_DIV: state_nxt = S_SS;
                  S_SS:  state_nxt = S_GO;
                  S_GO:  state_nxt = S_POLL;
                  S_POLL: begin
                     if (!wb_dat_i[8]) begin
                        state_nxt = S_RX;
                     end else begin
                        cnt_nxt = poll_cnt + 16'd1;
                        if ((poll_cnt + 16'd1) == POLL_MAX) begin
                           err_nxt   = 1'b1;
                           state_nxt = S_DESEL;
                        end
                     end
                  end
                  S_RX: begin
                     rx_nxt    = {wb_dat_i[7:0], wb_dat_i[15:8], wb_dat_i[23:16], wb_dat_i[31:24]};
                     state_nxt = S_DESEL;
                  end
                  S_DESEL: begin
                     xack_nxt  = 1'b1;
                     xdat_nxt  = err_q ? 32'h0 : rx_q;
                     xerr_nxt  = err_q;
                     state_nxt = S_RESP;
                  end
                  default: begin end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         ptr_xip   <= 1'b1;
         poll_cnt  <= '0;
         err_q     <= 1'b0;
         rx_q      <= '0;
         wb_cyc_o  <= 1'b0;
         wb_adr_o  <= '0;
         wb_dat_o  <= '0;
         wb_sel_o  <= '0;
         wb_we_o   <= 1'b0;
         xip_ack   <= 1'b0;
         xip_rdata <= '0;
         xip_err   <= 1'b0;
         reg_ack   <= 1'b0;
         reg_rdata <= '0;
      end else begin
         state     <= state_nxt;
         ptr_xip   <= ptr_nxt;
         poll_cnt  <= cnt_nxt;
         err_q     <= err_nxt;
         rx_q      <= rx_nxt;
         wb_cyc_o  <= cyc_nxt;
         wb_adr_o  <= adr_nxt;
         wb_dat_o  <= dat_nxt;
         wb_sel_o  <= sel_nxt;
         wb_we_o   <= we_nxt;
         xip_ack   <= xack_nxt;
         xip_rdata <= xdat_nxt;
         xip_err   <= xerr_nxt;
         reg_ack   <= rack_nxt;
         reg_rdata <= rdat_nxt;
      end
   end

endmodule

// File: tb/tb_spi_xip_arbiter.sv
// Bench for spi_xip_arbiter: Wishbone slave model plus scoreboards of expected bus cycles and acks.
module tb_spi_xip_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        xip_req;
   logic [23:0] xip_addr;
   logic        xip_ack;
   logic [31:0] xip_rdata;
   logic        xip_err;
   logic        reg_req;
   logic        reg_we;
   logic [4:0]  reg_adr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_sel;
   logic        reg_ack;
   logic [31:0] reg_rdata;
   logic [4:0]  wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        busy;

   always #5 clock = ~clock;

   spi_xip_arbiter #(.POLL_MAX(16'd4)) dut (
      .clock(clock), .reset(reset),
      .xip_req(xip_req), .xip_addr(xip_addr), .xip_ack(xip_ack),
      .xip_rdata(xip_rdata), .xip_err(xip_err),
      .reg_req(reg_req), .reg_we(reg_we), .reg_adr(reg_adr),
      .reg_wdata(reg_wdata), .reg_sel(reg_sel),
      .reg_ack(reg_ack), .reg_rdata(reg_rdata),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .busy(busy)
   );

   // ---------------- slave model ----------------
   int          s_wait = 0;
   int          s_busy_n = 0;
   bit          s_stuck = 1'b0;
   logic [31:0] s_rx = 32'h0;
   int          s_wcnt;
   int          s_poll_idx;

   function automatic logic [31:0] slave_val(input logic [4:0] adr);
      return 32'hA5A5_0000 | {27'b0, adr};
   endfunction

   function automatic logic [31:0] swap32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   assign wb_ack_i = wb_stb_o && (s_wcnt == s_wait);

   always_comb begin
      wb_dat_i = slave_val(wb_adr_o);
      if (wb_adr_o == 5'h10)
         wb_dat_i = {23'b0, (s_stuck || (s_poll_idx < s_busy_n)), 8'h40};
      else if (wb_adr_o == 5'h00)
         wb_dat_i = s_rx;
   end

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         s_wcnt     <= 0;
         s_poll_idx <= 0;
      end else begin
         if (wb_stb_o && !wb_ack_i) s_wcnt <= s_wcnt + 1;
         else                       s_wcnt <= 0;
         if (wb_stb_o && wb_ack_i) begin
            if (wb_we_o && wb_adr_o == 5'h04)       s_poll_idx <= 0;
            else if (!wb_we_o && wb_adr_o == 5'h10) s_poll_idx <= s_poll_idx + 1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic        we;
      logic [4:0]  adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } bus_t;

   bus_t        exp_bus[$];
   logic [32:0] exp_xip[$];
   logic [31:0] exp_reg[$];
   bus_t        m_got, m_exp;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push_bus(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
      bus_t b;
      b.we  = we;
      b.adr = adr;
      b.dat = we ? dat : 32'h0;
      b.sel = we ? sel : 4'h0;
      exp_bus.push_back(b);
   endtask

   always @(negedge clock) begin
      if (wb_stb_o && wb_ack_i) begin
         m_got.we  = wb_we_o;
         m_got.adr = wb_adr_o;
         m_got.dat = wb_we_o ? wb_dat_o : 32'h0;
         m_got.sel = wb_we_o ? wb_sel_o : 4'h0;
         if (exp_bus.size() == 0) begin
            total++; bad++;
            $display("FAIL bus_unexpected: got %0h want none", m_got);
         end else begin
            m_exp = exp_bus.pop_front();
            chk("bus_txn", 64'(m_got), 64'(m_exp));
         end
      end
      if (xip_ack) begin
         if (exp_xip.size() == 0) begin
            total++; bad++;
            $display("FAIL xip_ack_unexpected: got %0h want none", {xip_err, xip_rdata});
         end else begin
            chk("xip_resp", 64'({xip_err, xip_rdata}), 64'(exp_xip.pop_front()));
         end
      end
      if (reg_ack) begin
         if (exp_reg.size() == 0) begin
            total++; bad++;
            $display("FAIL reg_ack_unexpected: got %0h want none", reg_rdata);
         end else begin
            chk("reg_rdata", 64'(reg_rdata), 64'(exp_reg.pop_front()));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push_xip(input logic [23:0] addr, input int nbusy, input bit err,
                           input logic [31:0] rx);
      push_bus(1'b1, 5'h04, {8'h03, addr}, 4'hF);
      push_bus(1'b1, 5'h14, 32'h1, 4'hF);
      push_bus(1'b1, 5'h18, 32'h1, 4'hF);
      push_bus(1'b1, 5'h10, 32'h140, 4'hF);
      for (int i = 0; i < (err ? 4 : nbusy + 1); i++) push_bus(1'b0, 5'h10, 32'h0, 4'h0);
      if (!err) push_bus(1'b0, 5'h00, 32'h0, 4'h0);
      push_bus(1'b1, 5'h18, 32'h0, 4'hF);
      exp_xip.push_back({err, err ? 32'h0 : swap32(rx)});
   endtask

   task automatic xip_read(input logic [23:0] addr, input int nbusy, input bit err,
                           input logic [31:0] rx);
      bit done = 1'b0;
      s_busy_n = nbusy;
      s_rx     = rx;
      push_xip(addr, nbusy, err, rx);
      xip_addr = addr;
      xip_req  = 1'b1;
      for (int c = 0; c < 400 && !done; c++) begin
         step();
         if (xip_ack) begin
            xip_req = 1'b0;
            done    = 1'b1;
         end
      end
      if (!done) begin
         total++; bad++;
         xip_req = 1'b0;
         $display("FAIL xip_timeout: got no xip_ack want xip_ack");
      end
      step();
   endtask

   task automatic both_seq(input bit reg_first);
      int rc = 0;
      int xc = 0;
      s_wait   = 0;
      s_busy_n = 0;
      s_rx     = 32'hDEAD_BEEF;
      if (reg_first) begin
         push_bus(1'b1, 5'h0C, 32'h0000_CAFE, 4'hF);
         exp_reg.push_back(slave_val(5'h0C));
         push_xip(24'h00_0100, 0, 1'b0, 32'hDEAD_BEEF);
      end else begin
         push_xip(24'h00_0100, 0, 1'b0, 32'hDEAD_BEEF);
         push_bus(1'b1, 5'h0C, 32'h0000_CAFE, 4'hF);
         exp_reg.push_back(slave_val(5'h0C));
      end
      xip_addr  = 24'h00_0100;
      reg_we    = 1'b1;
      reg_adr   = 5'h0C;
      reg_wdata = 32'h0000_CAFE;
      reg_sel   = 4'hF;
      xip_req   = 1'b1;
      reg_req   = 1'b1;
      for (int c = 1; c < 400 && (rc == 0 || xc == 0); c++) begin
         step();
         if (reg_ack) begin reg_req = 1'b0; rc = c; end
         if (xip_ack) begin xip_req = 1'b0; xc = c; end
      end
      if (rc == 0 || xc == 0) begin
         total++; bad++;
         reg_req = 1'b0;
         xip_req = 1'b0;
         $display("FAIL both_timeout: got rc=%0d xc=%0d want both nonzero", rc, xc);
      end else begin
         chk("arb_order", 64'(rc < xc), 64'(reg_first));
      end
      step();
   endtask

   // ---------------- test ----------------
   typedef struct {
      logic        we;
      logic [4:0]  adr;
      logic [31:0] wdata;
      logic [3:0]  sel;
      int          waitc;
      int          lat;
   } rvec_t;

   rvec_t tbl[4];
   int    n;
   int    acks;
   bit    seen;

   initial begin
      tbl[0] = '{1'b1, 5'h14, 32'h0000_0005, 4'hF, 0, 2};
      tbl[1] = '{1'b0, 5'h0C, 32'h0,         4'hF, 2, 4};
      tbl[2] = '{1'b1, 5'h18, 32'h0000_00AA, 4'h1, 1, 3};
      tbl[3] = '{1'b0, 5'h04, 32'h0,         4'h3, 0, 2};

      reset = 1'b0; xip_req = 1'b0; xip_addr = '0;
      reg_req = 1'b0; reg_we = 1'b0; reg_adr = '0; reg_wdata = '0; reg_sel = '0;

      // reset hold and release with no requests
      repeat (3) step();
      chk("rst_cyc", 64'(wb_cyc_o), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      reset = 1'b1;
      repeat (2) step();
      chk("idle_xip_ack", 64'(xip_ack), 64'(0));
      chk("idle_xip_rdata", 64'(xip_rdata), 64'(0));
      chk("idle_xip_err", 64'(xip_err), 64'(0));
      chk("idle_reg_ack", 64'(reg_ack), 64'(0));
      chk("idle_reg_rdata", 64'(reg_rdata), 64'(0));
      chk("idle_adr", 64'(wb_adr_o), 64'(0));
      chk("idle_dat", 64'(wb_dat_o), 64'(0));
      chk("idle_sel", 64'(wb_sel_o), 64'(0));
      chk("idle_we", 64'(wb_we_o), 64'(0));
      chk("idle_stb", 64'(wb_stb_o), 64'(0));
      chk("idle_cyc", 64'(wb_cyc_o), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));

      // contention: register first from reset, then XIP wins
      both_seq(1'b1);
      both_seq(1'b0);

      // XIP read, one wait state, two busy polls
      s_wait = 1;
      xip_read(24'h00_1234, 2, 1'b0, 32'h1122_3344);

      // register vectors
      for (int i = 0; i < 4; i++) begin
         s_wait = tbl[i].waitc;
         push_bus(tbl[i].we, tbl[i].adr, tbl[i].wdata, tbl[i].sel);
         exp_reg.push_back(slave_val(tbl[i].adr));
         reg_we    = tbl[i].we;
         reg_adr   = tbl[i].adr;
         reg_wdata = tbl[i].wdata;
         reg_sel   = tbl[i].sel;
         reg_req   = 1'b1;
         n    = 0;
         seen = 1'b0;
         for (int c = 0; c < 50 && !seen; c++) begin
            step();
            n++;
            if (reg_ack) seen = 1'b1;
         end
         reg_req = 1'b0;
         chk("reg_latency", 64'(n), 64'(tbl[i].lat));
         step();
      end

      // timeout: CTRL busy stuck
      s_wait  = 0;
      s_stuck = 1'b1;
      xip_read(24'hAB_CDEF, 0, 1'b1, 32'h5566_7788);
      s_stuck = 1'b0;

      // reset during the GO cycle
      s_wait   = 6;
      s_busy_n = 0;
      push_bus(1'b1, 5'h04, {8'h03, 24'h00_0ABC}, 4'hF);
      push_bus(1'b1, 5'h14, 32'h1, 4'hF);
      push_bus(1'b1, 5'h18, 32'h1, 4'hF);
      xip_addr = 24'h00_0ABC;
      xip_req  = 1'b1;
      seen     = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         step();
         if (wb_cyc_o && wb_we_o && wb_adr_o == 5'h10) seen = 1'b1;
      end
      chk("go_reached", 64'(seen), 64'(1));
      step();
      reset = 1'b0;
      #1;
      chk("rst_mid_cyc", 64'(wb_cyc_o), 64'(0));
      chk("rst_mid_stb", 64'(wb_stb_o), 64'(0));
      chk("rst_mid_busy", 64'(busy), 64'(0));
      xip_req = 1'b0;
      repeat (2) step();
      reset = 1'b1;
      acks = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (xip_ack) acks++;
      end
      chk("no_ack_after_rst", 64'(acks), 64'(0));
      s_wait = 0;
      xip_read(24'h00_0ABC, 1, 1'b0, 32'hA1B2_C3D4);

      repeat (3) step();
      chk("bus_queue_empty", 64'(exp_bus.size()), 64'(0));
      chk("xip_queue_empty", 64'(exp_xip.size()), 64'(0));
      chk("reg_queue_empty", 64'(exp_reg.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
